tensor3d_stream_tx: RTL

//  Transmit side for 3D weight/feature tensors (DIM3 x DIM1 x DIM2 words, IEEE-754 single).
//  On start, snapshots a parallel 3D array into an internal buffer.

---
 rtl/tensor3d_stream_tx_if.sv | 10 +
 rtl/tensor3d_stream_tx.sv | 73 +++++++
 2 files changed

// File: rtl/tensor3d_stream_tx_if.sv
// tensor3d_stream_tx_if: valid/ready word stream carrying tensor words with channel/tensor end markers.
interface tensor3d_stream_tx_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             out_ch_last;
    modport master (output out_data, out_valid, out_last, out_ch_last, input out_ready);
    modport slave  (input out_data, out_valid, out_last, out_ch_last, output out_ready);
endinterface

// File: rtl/tensor3d_stream_tx.sv
// tensor3d_stream_tx: snapshots a 3D tensor on start and streams it channel/row/column-major over a valid/ready link.
module tensor3d_stream_tx #(
    parameter int DIM1  = 2,
    parameter int DIM2  = 2,
    parameter int DIM3  = 6,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data [DIM3][DIM1][DIM2],
    output logic             busy,
    output logic             done,
    tensor3d_stream_tx_if.master tx
);
    localparam int CW = DIM3 > 1 ? $clog2(DIM3) : 1;
    localparam int RW = DIM1 > 1 ? $clog2(DIM1) : 1;
    localparam int KW = DIM2 > 1 ? $clog2(DIM2) : 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    ch, ch_nx;
    logic [RW-1:0]    row, row_nx;
    logic [KW-1:0]    col, col_nx;
    logic [WIDTH-1:0] mem [DIM3][DIM1][DIM2];
    logic             ch_end, row_end, col_end, last, xfer;
    assign ch_end  = ch == CW'(DIM3 - 1);
    assign row_end = row == RW'(DIM1 - 1);
    assign col_end = col == KW'(DIM2 - 1);
    assign last    = ch_end && row_end && col_end;
    assign busy            = state == SEND;
    assign tx.out_valid    = state == SEND;
    assign tx.out_last     = busy && last;
    assign tx.out_ch_last  = busy && row_end && col_end;
    assign tx.out_data     = busy ? mem[ch][row][col] : '0;
    assign xfer            = tx.out_valid && tx.out_ready;
    // Buffer is only written while idle, so words in flight never see in_data changes
    always_ff @(posedge clk)
        if (state == IDLE && start) mem <= in_data;
    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        row_nx   = row;
        col_nx   = col;
        if (state == IDLE) begin
            if (start) begin
                state_nx = SEND;
                ch_nx    = '0;
                row_nx   = '0;
                col_nx   = '0;
            end
        end else if (xfer) begin
            col_nx   = col_end ? '0 : col + 1'b1;
            row_nx   = col_end ? (row_end ? '0 : row + 1'b1) : row;
            ch_nx    = col_end && row_end ? (ch_end ? '0 : ch + 1'b1) : ch;
            state_nx = last ? IDLE : SEND;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            row   <= '0;
            col   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
            row   <= row_nx;
            col   <= col_nx;
            done  <= xfer && last;
        end
    end
endmodule
